lfsr_move_gen: RTL and testbench

Parametrised pseudo-random move generator for the Nim game datapath. A free-running Fibonacci LFSR supplies raw values. A request/valid FSM turns these into a legal move in the range 1..limit by rejection sampling. Attempts are bounded, with a deterministic fallback when the bound is reached. The block sits between the game controller, which supplies `limit` (the stones remaining, capped), and the move-apply logic.

---
 rtl/lfsr_move_gen_pkg.sv | 9 +
 rtl/lfsr_move_gen_if.sv | 26 ++
 rtl/lfsr_move_gen_core.sv | 31 +++
 rtl/lfsr_move_gen.sv | 105 ++++++++++
 tb/tb_lfsr_move_gen.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_move_gen_pkg.sv
// Shared types and default constants for the LFSR-based Nim move generator.
package lfsr_pkg;

    typedef enum logic [1:0] {IDLE, DRAW, DONE} move_state_t;

    localparam logic [15:0] LFSR16_TAPS = 16'hD004;
    localparam logic [15:0] LFSR16_SEED = 16'h0001;

endpackage

// File: rtl/lfsr_move_gen_if.sv
// Request/response and seeding signals between the game controller and the move generator.
interface lfsr_move_gen_if #(
    parameter int WIDTH = 16,
    parameter int OUT_W = 4
);
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic             req;
    logic [OUT_W-1:0] limit;
    logic             busy;
    logic             valid;
    logic [OUT_W-1:0] move;
    logic             fallback;
    // Current LFSR register, exported for observation.
    logic [WIDTH-1:0] lfsr_state;

    modport master (
        output seed_load, seed_in, req, limit,
        input  busy, valid, move, fallback, lfsr_state
    );

    modport slave (
        input  seed_load, seed_in, req, limit,
        output busy, valid, move, fallback, lfsr_state
    );
endinterface

// File: rtl/lfsr_move_gen_core.sv
// Free-running Fibonacci LFSR with seed load, zero-seed substitution and lockup recovery.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = LFSR16_TAPS,
    parameter logic [WIDTH-1:0] SEED  = LFSR16_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state
);
    logic [WIDTH-1:0] r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEED;
        end else if (load) begin
            // An all-zero seed would lock the register, so substitute SEED.
            r_state <= (load_val == '0) ? SEED : load_val;
        end else if (r_state == '0) begin
            r_state <= SEED;
        end else begin
            r_state <= {r_state[WIDTH-2:0], ^(r_state & TAPS)};
        end
    end

    assign state = r_state;
endmodule

// File: rtl/lfsr_move_gen.sv
// Nim move generator: rejection-samples LFSR output into 1..limit with a bounded retry count.
module lfsr_move_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = LFSR16_TAPS,
    parameter logic [WIDTH-1:0] SEED      = LFSR16_SEED,
    parameter int               OUT_W     = 4,
    parameter int               MAX_TRIES = 8
) (
    input  logic            clk,
    input  logic            reset,
    lfsr_move_gen_if.slave  bus
);
    localparam int            TW       = $clog2(MAX_TRIES) + 1;
    localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

    logic [WIDTH-1:0] w_lfsr;
    logic [OUT_W-1:0] w_cand;
    logic             w_hit;

    move_state_t      r_state;
    logic [TW-1:0]    r_tries;
    logic [OUT_W-1:0] r_limit;
    logic [OUT_W-1:0] r_move;
    logic             r_busy;
    logic             r_valid;
    logic             r_fallback;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (bus.seed_load),
        .load_val (bus.seed_in),
        .state    (w_lfsr)
    );

    // The candidate is taken from the pre-edge register, so a same-cycle seed load does not affect it.
    assign w_cand = w_lfsr[OUT_W-1:0];
    assign w_hit  = (w_cand != '0) && (w_cand <= r_limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tries    <= '0;
            r_limit    <= '0;
            r_move     <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_fallback <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.req) begin
                        r_busy <= 1'b1;
                        if (bus.limit != '0) begin
                            r_limit <= bus.limit;
                            r_tries <= '0;
                            r_state <= DRAW;
                        end else begin
                            r_move     <= '0;
                            r_fallback <= 1'b1;
                            r_valid    <= 1'b1;
                            r_state    <= DONE;
                        end
                    end
                end
                DRAW: begin
                    if (w_hit) begin
                        r_move     <= w_cand;
                        r_fallback <= 1'b0;
                        r_valid    <= 1'b1;
                        r_state    <= DONE;
                    end else if (r_tries == LAST_TRY) begin
                        r_move     <= OUT_W'(1);
                        r_fallback <= 1'b1;
                        r_valid    <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_tries <= r_tries + TW'(1);
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.valid      = r_valid;
    assign bus.move       = r_move;
    assign bus.fallback   = r_fallback;
    assign bus.lfsr_state = w_lfsr;
endmodule

// File: tb/tb_lfsr_move_gen.sv
// Self-checking bench for lfsr_move_gen: LFSR vector table, directed corner cases and a randomized model comparison.
module tb_lfsr_move_gen;
    localparam int MT = 8;

    logic       clk;
    logic       reset;
    logic [3:0] limit_b;
    logic [15:0] m_reg;
    int         n_cmp;
    int         n_err;

    lfsr_move_gen_if #(.WIDTH(16), .OUT_W(4)) ifa ();
    lfsr_move_gen_if #(.WIDTH(16), .OUT_W(4)) ifb ();

    lfsr_move_gen #(
        .WIDTH(16), .TAPS(16'hD004), .SEED(16'h0001), .OUT_W(4), .MAX_TRIES(MT)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );

    lfsr_move_gen #(
        .WIDTH(16), .TAPS(16'hD004), .SEED(16'h0001), .OUT_W(4), .MAX_TRIES(1)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    assign ifb.seed_load = ifa.seed_load;
    assign ifb.seed_in   = ifa.seed_in;
    assign ifb.req       = ifa.req;
    assign ifb.limit     = limit_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic [15:0] val;
        logic [15:0] exp;
    } lvec_t;

    lvec_t tbl[10];

    // Shift left, feedback = parity of tapped bits, computed with counting arithmetic.
    function automatic logic [15:0] lfsr_next(input logic [15:0] r);
        logic [15:0] taps;
        int          ones;
        int          v;
        taps = 16'hD004;
        ones = 0;
        for (int i = 0; i < 16; i++)
            if (r[i] && taps[i]) ones++;
        v = (int'(r) * 2 + (ones % 2)) % 65536;
        return v[15:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [15:0] nx;
        if (reset)                  nx = 16'h0001;
        else if (ifa.seed_load)     nx = (ifa.seed_in == 16'h0) ? 16'h0001 : ifa.seed_in;
        else if (m_reg == 16'h0)    nx = 16'h0001;
        else                        nx = lfsr_next(m_reg);
        @(posedge clk);
        #1;
        m_reg = nx;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ifa.req = 1'b0;
        ifa.seed_load = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Issues one request from IDLE; returns in the IDLE cycle following the valid pulse.
    task automatic do_req(input logic [3:0] lim, input bit hold);
        int          lat;
        logic [3:0]  em;
        logic        ef;
        logic [15:0] r;
        if (lim == 4'd0) begin
            lat = 1; em = 4'd0; ef = 1'b1;
        end else begin
            lat = 1 + MT; em = 4'd1; ef = 1'b1;
            r = m_reg;
            for (int k = 0; k < MT; k++) begin
                r = lfsr_next(r);
                if (r[3:0] != 4'd0 && r[3:0] <= lim) begin
                    lat = 2 + k; em = r[3:0]; ef = 1'b0;
                    break;
                end
            end
        end
        ifa.req = 1'b1;
        ifa.limit = lim;
        for (int c = 1; c <= lat; c++) begin
            tick();
            if (!hold) ifa.req = 1'b0;
            chk("busy_in_req", 32'(ifa.busy), 32'd1);
            if (c < lat) begin
                chk("valid_early", 32'(ifa.valid), 32'd0);
            end else begin
                chk("valid_pulse", 32'(ifa.valid), 32'd1);
                chk("move", 32'(ifa.move), 32'(em));
                chk("fallback", 32'(ifa.fallback), 32'(ef));
            end
        end
        tick();
        chk("valid_after", 32'(ifa.valid), 32'd0);
        chk("busy_after", 32'(ifa.busy), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_reg = 16'h0001;
        limit_b = 4'd10;
        ifa.req = 1'b0;
        ifa.limit = 4'd0;
        ifa.seed_load = 1'b0;
        ifa.seed_in = 16'h0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_reg", 32'(ifa.lfsr_state), 32'h0001);
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_valid", 32'(ifa.valid), 32'd0);
        chk("rst_move", 32'(ifa.move), 32'd0);
        chk("rst_fallback", 32'(ifa.fallback), 32'd0);

        tbl[0] = '{1'b0, 16'h0000, 16'h0002};
        tbl[1] = '{1'b0, 16'h0000, 16'h0004};
        tbl[2] = '{1'b0, 16'h0000, 16'h0009};
        tbl[3] = '{1'b0, 16'h0000, 16'h0012};
        tbl[4] = '{1'b1, 16'h0000, 16'h0001};
        tbl[5] = '{1'b0, 16'h0000, 16'h0002};
        tbl[6] = '{1'b1, 16'h0005, 16'h0005};
        tbl[7] = '{1'b0, 16'h0000, 16'h000B};
        tbl[8] = '{1'b0, 16'h0000, 16'h0016};
        tbl[9] = '{1'b0, 16'h0000, 16'h002D};
        for (int i = 0; i < 10; i++) begin
            ifa.seed_load = tbl[i].ld;
            ifa.seed_in = tbl[i].val;
            tick();
            ifa.seed_load = 1'b0;
            chk($sformatf("lfsr_vec%0d", i), 32'(ifa.lfsr_state), 32'(tbl[i].exp));
        end

        // First-draw accept on A; MAX_TRIES=1 fallback on B from the same register sequence.
        do_reset();
        ifa.seed_load = 1'b1;
        ifa.seed_in = 16'h0005;
        tick();
        ifa.seed_load = 1'b0;
        ifa.req = 1'b1;
        ifa.limit = 4'd15;
        tick();
        ifa.req = 1'b0;
        chk("draw_reg", 32'(ifa.lfsr_state), 32'h000B);
        chk("draw_busy", 32'(ifa.busy), 32'd1);
        chk("draw_valid0", 32'(ifa.valid), 32'd0);
        chk("fb_busy", 32'(ifb.busy), 32'd1);
        tick();
        chk("draw_valid", 32'(ifa.valid), 32'd1);
        chk("draw_move", 32'(ifa.move), 32'd11);
        chk("draw_fallback", 32'(ifa.fallback), 32'd0);
        chk("draw_busy2", 32'(ifa.busy), 32'd1);
        chk("fb_valid", 32'(ifb.valid), 32'd1);
        chk("fb_move", 32'(ifb.move), 32'd1);
        chk("fb_fallback", 32'(ifb.fallback), 32'd1);
        tick();
        chk("draw_valid_end", 32'(ifa.valid), 32'd0);
        chk("draw_busy_end", 32'(ifa.busy), 32'd0);

        do_req(4'd0, 1'b0);

        // Held request: each response must be followed by a fresh accept, never an overlap.
        ifa.req = 1'b1;
        for (int i = 0; i < 6; i++)
            do_req(4'($urandom_range(0, 15)), 1'b1);
        ifa.req = 1'b0;

        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 3) == 0) begin
                    ifa.seed_load = 1'b1;
                    ifa.seed_in = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
                end
                tick();
                ifa.seed_load = 1'b0;
            end
            chk("rand_reg", 32'(ifa.lfsr_state), 32'(m_reg));
            do_req(4'($urandom_range(0, 15)), 1'b0);
        end

        // Reset while drawing: candidate 11 > limit 1 keeps the FSM in DRAW.
        do_reset();
        ifa.seed_load = 1'b1;
        ifa.seed_in = 16'h0005;
        tick();
        ifa.seed_load = 1'b0;
        ifa.req = 1'b1;
        ifa.limit = 4'd1;
        tick();
        ifa.req = 1'b0;
        chk("abort_busy_pre", 32'(ifa.busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_reg", 32'(ifa.lfsr_state), 32'h0001);
        chk("abort_busy", 32'(ifa.busy), 32'd0);
        chk("abort_valid", 32'(ifa.valid), 32'd0);
        chk("abort_move", 32'(ifa.move), 32'd0);
        chk("abort_fallback", 32'(ifa.fallback), 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("abort_no_valid", 32'(ifa.valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
